// File: rtl/rtc_pdu_pkg.sv
// rtc_pdu_pkg: shared APB address map, handshake state encoding and parameter limits
package rtc_pdu_pkg;
    localparam logic [11:0] ADDR_CNT      = 12'h000;
    localparam logic [11:0] ADDR_DIV      = 12'h004;
    localparam logic [11:0] ADDR_CR       = 12'h008;
    localparam logic [11:0] ADDR_CLR      = 12'h00C;
    localparam logic [11:0] ADDR_STAT     = 12'h010;
    localparam logic [11:0] ADDR_INT_RAW  = 12'h014;
    localparam logic [11:0] ADDR_INT_STAT = 12'h018;
    localparam logic [11:0] ADDR_EOI      = 12'h01C;
    localparam logic [11:0] ADDR_MR0      = 12'h020;

    localparam int NUM_MATCH_MIN = 1;
    localparam int NUM_MATCH_MAX = 4;
    localparam int CNT_WIDTH_MIN = 16;
    localparam int CNT_WIDTH_MAX = 32;
    localparam int DIV_WIDTH_MIN = 1;
    localparam int DIV_WIDTH_MAX = 24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hs_state_e;

    function automatic logic [11:0] mr_addr(input int i);
        return ADDR_MR0 + 12'(4 * i);
    endfunction
endpackage

// File: rtl/rtc_cnt_sync_filter.sv
// rtc_cnt_sync_filter: two-flop synchroniser plus stability filter for the AOU counter
// Ports:
//   pclk, presetn  clock, async active-low reset
//   test_mode      routes din straight to dout
//   din            counter from the AOU domain (asynchronous)
//   dout           filtered counter value in the pclk domain
module rtc_cnt_sync_filter #(
    parameter int WIDTH = 32
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             test_mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] s1, s2, s3, cnt_sync;

    // A multi-bit value crossing mid-transition can be captured torn; only
    // accept a sample once it has been seen twice in a row.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            cnt_sync <= '0;
        end else begin
            s1       <= din;
            s2       <= s1;
            s3       <= s2;
            cnt_sync <= (s2 == s3) ? s2 : cnt_sync;
        end
    end

    assign dout = test_mode ? din : cnt_sync;
endmodule

// File: rtl/rtc_pdu_mch_apbif.sv
// rtc_pdu_mch_apbif: APB slave bridging register access to the always-on RTC domain
// Ports:
//   pclk, presetn                  APB clock, async active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready, pslverr  APB slave, zero wait states
//   aou_pdu_cnt                    AOU counter (asynchronous)
//   aou_pdu_div_reg/cr_reg/mr_reg  AOU register readback (quasi-static)
//   aou_pdu_int_flag/intr_mask     per-channel raw flags and masks
//   aou_pdu_ack                    toggle acknowledge (asynchronous)
//   pdu_aou_req, pdu_aou_wdata     toggle request and held write data
//   pdu_aou_wen_*                  one-cycle write enables
//   pdu_aou_int_clr                one-cycle interrupt clear pulses
//   intr                           registered OR of unmasked flags
//   test_mode                      bypasses the synchronisers
module rtc_pdu_mch_apbif
    import rtc_pdu_pkg::*;
#(
    parameter int NUM_MATCH = 2,
    parameter int CNT_WIDTH = 32,
    parameter int DIV_WIDTH = 20
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [11:0]                    paddr,
    input  logic [31:0]                    pwdata,
    output logic [31:0]                    prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic [CNT_WIDTH-1:0]           aou_pdu_cnt,
    input  logic [DIV_WIDTH-1:0]           aou_pdu_div_reg,
    input  logic [3:0]                     aou_pdu_cr_reg,
    input  logic [NUM_MATCH*CNT_WIDTH-1:0] aou_pdu_mr_reg,
    input  logic [NUM_MATCH-1:0]           aou_pdu_int_flag,
    input  logic [NUM_MATCH-1:0]           aou_pdu_intr_mask,
    input  logic                           aou_pdu_ack,
    output logic                           pdu_aou_req,
    output logic [31:0]                    pdu_aou_wdata,
    output logic                           pdu_aou_wen_cr,
    output logic                           pdu_aou_wen_div,
    output logic                           pdu_aou_wen_clr,
    output logic [NUM_MATCH-1:0]           pdu_aou_wen_mr,
    output logic [NUM_MATCH-1:0]           pdu_aou_int_clr,
    output logic                           intr,
    input  logic                           test_mode
);
    hs_state_e state, state_nxt;
    logic setup, acc, hs_addr, wr_ok, ack_q1, ack_q2, ack_s, err_q;
    logic [NUM_MATCH-1:0] mr_hit;
    logic [CNT_WIDTH-1:0] cnt_rd;
    logic [31:0] rd_mux;

    rtc_cnt_sync_filter #(.WIDTH(CNT_WIDTH)) u_cnt_sync (
        .pclk      (pclk),
        .presetn   (presetn),
        .test_mode (test_mode),
        .din       (aou_pdu_cnt),
        .dout      (cnt_rd)
    );

    assign setup   = psel & ~penable;
    assign acc     = psel & penable;
    assign pready  = 1'b1;
    assign pslverr = err_q;
    assign ack_s   = test_mode ? aou_pdu_ack : ack_q2;
    assign hs_addr = (paddr == ADDR_DIV) | (paddr == ADDR_CR) | (paddr == ADDR_CLR) | (|mr_hit);
    // The busy decision is taken once, in the setup phase, so pslverr and
    // acceptance cannot disagree if the ack lands between the two phases.
    assign wr_ok   = acc & pwrite & hs_addr & ~err_q & (state == ST_IDLE);

    assign state_nxt = (state == ST_IDLE) ? (wr_ok ? ST_BUSY : ST_IDLE)
                                          : ((ack_s == pdu_aou_req) ? ST_IDLE : ST_BUSY);

    always_comb begin
        rd_mux = '0;
        mr_hit = '0;
        case (paddr)
            ADDR_CNT:      rd_mux = 32'(cnt_rd);
            ADDR_DIV:      rd_mux = 32'(aou_pdu_div_reg);
            ADDR_CR:       rd_mux = 32'(aou_pdu_cr_reg);
            ADDR_STAT:     rd_mux = 32'(state == ST_BUSY);
            ADDR_INT_RAW:  rd_mux = 32'(aou_pdu_int_flag);
            ADDR_INT_STAT: rd_mux = 32'(aou_pdu_int_flag & ~aou_pdu_intr_mask);
            default:       ;
        endcase
        for (int i = 0; i < NUM_MATCH; i++) begin
            mr_hit[i] = (paddr == mr_addr(i));
            rd_mux    = mr_hit[i] ? 32'(aou_pdu_mr_reg[i*CNT_WIDTH +: CNT_WIDTH]) : rd_mux;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state           <= ST_IDLE;
            ack_q1          <= 1'b0;
            ack_q2          <= 1'b0;
            err_q           <= 1'b0;
            prdata          <= '0;
            pdu_aou_req     <= 1'b0;
            pdu_aou_wdata   <= '0;
            pdu_aou_wen_cr  <= 1'b0;
            pdu_aou_wen_div <= 1'b0;
            pdu_aou_wen_clr <= 1'b0;
            pdu_aou_wen_mr  <= '0;
            pdu_aou_int_clr <= '0;
            intr            <= 1'b0;
        end else begin
            state           <= state_nxt;
            ack_q1          <= aou_pdu_ack;
            ack_q2          <= ack_q1;
            // Response fields are captured in setup so they are stable for the whole access phase.
            err_q           <= setup & pwrite & hs_addr & (state == ST_BUSY);
            prdata          <= (setup & ~pwrite) ? rd_mux : '0;
            pdu_aou_req     <= wr_ok ? ~pdu_aou_req : pdu_aou_req;
            pdu_aou_wdata   <= wr_ok ? pwdata : pdu_aou_wdata;
            pdu_aou_wen_div <= wr_ok & (paddr == ADDR_DIV);
            pdu_aou_wen_cr  <= wr_ok & (paddr == ADDR_CR);
            pdu_aou_wen_clr <= wr_ok & (paddr == ADDR_CLR);
            pdu_aou_wen_mr  <= wr_ok ? mr_hit : '0;
            pdu_aou_int_clr <= (acc & pwrite & (paddr == ADDR_EOI)) ? pwdata[NUM_MATCH-1:0] : '0;
            intr            <= |(aou_pdu_int_flag & ~aou_pdu_intr_mask);
        end
    end
endmodule

// File: tb/tb_rtc_pdu_mch_apbif.sv
// tb_rtc_pdu_mch_apbif: self-checking bench for rtc_pdu_mch_apbif
module tb_rtc_pdu_mch_apbif;
    localparam int NM = 2;
    localparam int CW = 32;
    localparam int DW = 20;
    localparam int PW = NM + 3;

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    logic pclk = 0, presetn = 0, psel = 0, penable = 0, pwrite = 0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic pready, pslverr;
    logic [CW-1:0] cnt = '0;
    logic [DW-1:0] div = '0;
    logic [3:0] cr = '0;
    logic [NM*CW-1:0] mr = '0;
    logic [NM-1:0] flag = '0, mask = '0;
    logic ack = 0, test_mode = 0;
    logic req, wen_cr, wen_div, wen_clr, intr;
    logic [31:0] wdata;
    logic [NM-1:0] wen_mr, int_clr;
    logic [PW-1:0] pulses;
    int errors = 0, checks = 0;
    vec_t tbl [16];
    logic [11:0] addrs [14] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018,
                                12'h01C, 12'h020, 12'h024, 12'h028, 12'h02C, 12'h022, 12'h400};

    assign pulses = {wen_mr, wen_clr, wen_cr, wen_div};

    rtc_pdu_mch_apbif #(.NUM_MATCH(NM), .CNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .aou_pdu_cnt(cnt), .aou_pdu_div_reg(div), .aou_pdu_cr_reg(cr), .aou_pdu_mr_reg(mr),
        .aou_pdu_int_flag(flag), .aou_pdu_intr_mask(mask), .aou_pdu_ack(ack),
        .pdu_aou_req(req), .pdu_aou_wdata(wdata), .pdu_aou_wen_cr(wen_cr),
        .pdu_aou_wen_div(wen_div), .pdu_aou_wen_clr(wen_clr), .pdu_aou_wen_mr(wen_mr),
        .pdu_aou_int_clr(int_clr), .intr(intr), .test_mode(test_mode)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the access edge.
    task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1;
        rd = prdata;
        err = pslverr;
        @(posedge pclk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wait_idle();
        logic [31:0] rd;
        logic er;
        rd = 32'h1;
        for (int k = 0; k < 10 && rd != 0; k++) apb(0, 12'h010, 0, rd, er);
        chk("stat_idle", rd, 0);
    endtask

    // Reference read value straight from the register map.
    function automatic logic [31:0] exp_rd(input logic [11:0] a, input logic busy);
        int idx;
        idx = (int'(a) - 32) / 4;
        if (a == 12'h000) return 32'(cnt);
        if (a == 12'h004) return 32'(div);
        if (a == 12'h008) return 32'(cr);
        if (a == 12'h010) return 32'(busy);
        if (a == 12'h014) return 32'(flag);
        if (a == 12'h018) return 32'(flag & ~mask);
        if (a[1:0] == 2'b00 && idx >= 0 && idx < NM) return 32'(mr >> (CW * idx));
        return 32'h0;
    endfunction

    // Expected {wen_mr, wen_clr, wen_cr, wen_div} for an accepted write.
    function automatic logic [PW-1:0] exp_wen(input logic [11:0] a);
        int idx;
        idx = (int'(a) - 32) / 4;
        if (a == 12'h004) return PW'(1);
        if (a == 12'h008) return PW'(2);
        if (a == 12'h00C) return PW'(4);
        if (a[1:0] == 2'b00 && idx >= 0 && idx < NM) return PW'(8 << idx);
        return '0;
    endfunction

    initial begin
        logic [31:0] rd, d;
        logic er, m_req;
        logic [11:0] a;
        logic [PW-1:0] ev;

        flag = 2'b01;
        @(posedge pclk); #1;
        chk("rst_req", 32'(req), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pulses", 32'(pulses), 0);
        chk("rst_int_clr", 32'(int_clr), 0);
        chk("rst_intr", 32'(intr), 0);
        chk("rst_pslverr", 32'(pslverr), 0);
        chk("rst_prdata", prdata, 0);
        chk("pready", 32'(pready), 1);
        flag = '0;
        presetn = 1;
        @(posedge pclk); #1;

        div = 20'h12345; cr = 4'hA; mr = {32'h00C0FFEE, 32'hDEADBEEF};
        flag = 2'b10; mask = 2'b01; cnt = 32'h5A5A;
        tbl[0]  = '{1'b0, 12'h000, 32'h0, 32'h0000_5A5A};
        tbl[1]  = '{1'b0, 12'h004, 32'h0, 32'h0001_2345};
        tbl[2]  = '{1'b0, 12'h008, 32'h0, 32'h0000_000A};
        tbl[3]  = '{1'b0, 12'h00C, 32'h0, 32'h0};
        tbl[4]  = '{1'b0, 12'h010, 32'h0, 32'h0};
        tbl[5]  = '{1'b0, 12'h014, 32'h0, 32'h2};
        tbl[6]  = '{1'b0, 12'h018, 32'h0, 32'h2};
        tbl[7]  = '{1'b0, 12'h01C, 32'h0, 32'h0};
        tbl[8]  = '{1'b0, 12'h020, 32'h0, 32'hDEAD_BEEF};
        tbl[9]  = '{1'b0, 12'h024, 32'h0, 32'h00C0_FFEE};
        tbl[10] = '{1'b0, 12'h028, 32'h0, 32'h0};
        tbl[11] = '{1'b0, 12'h3FC, 32'h0, 32'h0};
        tbl[12] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0};
        tbl[13] = '{1'b1, 12'h014, 32'hFFFF_FFFF, 32'h0};
        tbl[14] = '{1'b1, 12'h028, 32'h1234_5678, 32'h0};
        tbl[15] = '{1'b1, 12'h01C, 32'h0, 32'h0};
        repeat (6) @(posedge pclk); #1;
        for (int i = 0; i < 16; i++) begin
            apb(tbl[i].w, tbl[i].a, tbl[i].d, rd, er);
            chk("tbl_err", 32'(er), 0);
            if (tbl[i].w) begin
                chk("tbl_wr_pulses", 32'({pulses, int_clr}), tbl[i].exp);
                chk("tbl_wr_req", 32'(req), 0);
            end else chk("tbl_rd", rd, tbl[i].exp);
        end

        flag = '0; mask = '0;
        @(posedge pclk); #1;
        flag = 2'b10;
        chk("intr_before", 32'(intr), 0);
        @(posedge pclk); #1;
        chk("intr_set", 32'(intr), 1);
        mask = 2'b10;
        @(posedge pclk); #1;
        chk("intr_masked", 32'(intr), 0);
        apb(0, 12'h014, 0, rd, er);
        chk("int_raw", rd, 32'h2);
        apb(0, 12'h018, 0, rd, er);
        chk("int_stat", rd, 32'h0);

        apb(1, 12'h004, 32'h0000_00A5, rd, er);
        chk("div_err", 32'(er), 0);
        chk("div_pulses", 32'(pulses), 32'h1);
        chk("div_wdata", wdata, 32'hA5);
        chk("div_req", 32'(req), 1);
        @(posedge pclk); #1;
        chk("div_pulse_end", 32'(pulses), 0);
        apb(0, 12'h010, 0, rd, er);
        chk("stat_busy", rd, 1);
        ack = 1;
        apb(0, 12'h010, 0, rd, er);
        chk("stat_ack0", rd, 1);
        apb(0, 12'h010, 0, rd, er);
        chk("stat_ack1", rd, 1);
        apb(0, 12'h010, 0, rd, er);
        chk("stat_ack2", rd, 0);

        apb(1, 12'h008, 32'h5, rd, er);
        chk("cr_pulses", 32'(pulses), 32'h2);
        chk("cr_req", 32'(req), 0);
        apb(1, 12'h024, 32'h1234, rd, er);
        chk("busy_err", 32'(er), 1);
        chk("busy_pulses", 32'(pulses), 0);
        chk("busy_wdata", wdata, 32'h5);
        chk("busy_req", 32'(req), 0);
        apb(1, 12'h01C, 32'h3, rd, er);
        chk("eoi_err", 32'(er), 0);
        chk("eoi_clr", 32'(int_clr), 32'h3);
        @(posedge pclk); #1;
        chk("eoi_clr_end", 32'(int_clr), 0);

        apb(1, 12'h01C, 32'h1, rd, er);
        chk("eoi_clr1", 32'(int_clr), 32'h1);
        presetn = 0; ack = 0;
        #2;
        chk("rstb_int_clr", 32'(int_clr), 0);
        chk("rstb_req", 32'(req), 0);
        chk("rstb_wdata", wdata, 0);
        @(posedge pclk); #1;
        presetn = 1;
        @(posedge pclk); #1;
        apb(0, 12'h010, 0, rd, er);
        chk("rstb_stat", rd, 0);
        apb(1, 12'h020, 32'h55, rd, er);
        chk("rstb_wr_err", 32'(er), 0);
        chk("rstb_wr_pulses", 32'(pulses), 32'h8);
        chk("rstb_wr_req", 32'(req), 1);
        ack = 1;
        wait_idle();
        m_req = 1;

        for (int ph = 0; ph < 2; ph++) begin
            cnt = 32'h0000_FFFF;
            repeat (6) @(posedge pclk); #1;
            fork
                begin
                    repeat (ph + 1) @(posedge pclk);
                    #1 cnt = 32'h0001_FFFF;
                    @(posedge pclk);
                    #1 cnt = 32'h0001_0000;
                end
                begin
                    logic [31:0] gr;
                    logic ge;
                    for (int k = 0; k < 6; k++) begin
                        apb(0, 12'h000, 0, gr, ge);
                        chk("glitch_cnt", 32'((gr == 32'hFFFF) || (gr == 32'h1_0000)), 1);
                    end
                end
            join
            apb(0, 12'h000, 0, rd, er);
            chk("glitch_final", rd, 32'h1_0000);
        end
        test_mode = 1;
        cnt = 32'h777;
        apb(0, 12'h000, 0, rd, er);
        chk("test_mode_cnt", rd, 32'h777);
        test_mode = 0;

        for (int it = 0; it < 40; it++) begin
            div = DW'($urandom); cr = 4'($urandom); mr = {$urandom, $urandom};
            flag = NM'($urandom); mask = NM'($urandom); cnt = $urandom;
            repeat (6) @(posedge pclk); #1;
            chk("rnd_intr", 32'(intr), 32'(|(flag & ~mask)));
            a = addrs[$urandom_range(0, 13)];
            if ($urandom_range(0, 1) == 0) begin
                apb(0, a, 0, rd, er);
                chk("rnd_rd", rd, exp_rd(a, 1'b0));
                chk("rnd_rd_err", 32'(er), 0);
            end else begin
                d = $urandom;
                ev = exp_wen(a);
                apb(1, a, d, rd, er);
                chk("rnd_wr_err", 32'(er), 0);
                chk("rnd_wr_pulses", 32'(pulses), 32'(ev));
                chk("rnd_int_clr", 32'(int_clr), (a == 12'h01C) ? 32'(d[NM-1:0]) : 32'h0);
                if (ev != '0) begin
                    m_req = ~m_req;
                    chk("rnd_wdata", wdata, d);
                end
                chk("rnd_req", 32'(req), 32'(m_req));
                ack = m_req;
                wait_idle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rtc_pdu_mch_apbif.md
RTC_PDU_MCH_APBIF -- requirements
Module: rtc_pdu_mch_apbif

Interface
REQ-001 Parameters: NUM_MATCH, default 2, number of match channels (1..4); CNT_WIDTH, default 32, counter/match width (16..32); DIV_WIDTH, default 20, prescaler width (1..24).
REQ-002 Clocking SHALL be fixed as: one clock; reset is asynchronous and active-low (ports pclk and presetn).
REQ-003 pclk  in  1  APB/PDU clock.
REQ-004 presetn  in  1  async active-low reset.
REQ-005 psel, penable, pwrite  in  1 each  APB control.
REQ-006 paddr  in  12  byte address; pwdata  in  32  write data.
REQ-007 prdata  out  32; pready  out  1, tied 1; pslverr  out  1  APB response.
REQ-008 aou_pdu_cnt  in  CNT_WIDTH  AOU counter, asynchronous to pclk.
REQ-009 aou_pdu_div_reg  in  DIV_WIDTH; aou_pdu_cr_reg  in  4; aou_pdu_mr_reg  in  NUM_MATCH*CNT_WIDTH  AOU register readback, quasi-static.
REQ-010 aou_pdu_int_flag, aou_pdu_intr_mask  in  NUM_MATCH  per-channel raw flag and mask.
REQ-011 aou_pdu_ack  in  1  toggle acknowledge from AOU, asynchronous.
REQ-012 pdu_aou_req  out  1  toggle request; pdu_aou_wdata  out  32  held write data.
REQ-013 pdu_aou_wen_cr, pdu_aou_wen_div, pdu_aou_wen_clr  out  1 each; pdu_aou_wen_mr  out  NUM_MATCH; one-cycle pulses.
REQ-014 pdu_aou_int_clr  out  NUM_MATCH  one-cycle clear pulses.
REQ-015 intr  out  1  registered OR of unmasked flags; test_mode  in  1  sync bypass.

Function
REQ-016 Map: 0x00 CNT RO; 0x04 DIV RW; 0x08 CR RW; 0x0C CLR WO; 0x10 STAT RO (bit0 busy); 0x14 INT_RAW RO; 0x18 INT_STAT RO (flag & ~mask); 0x1C EOI W1C; 0x20+4*i MR[i] RW for i<NUM_MATCH.
REQ-017 Access SHALL take effect in the APB access phase (psel & penable); zero wait states.
REQ-018 Reads SHALL return zero-extended fields; unmapped and WO addresses read 0 with pslverr=0.
REQ-019 Handshake FSM states IDLE, BUSY; a write to DIV/CR/CLR/MR[i] in IDLE SHALL latch pdu_aou_wdata, pulse the matching wen for one cycle, toggle pdu_aou_req, enter BUSY.
REQ-020 aou_pdu_ack SHALL be synchronised through two flops (bypassed when test_mode=1); BUSY->IDLE when synced ack equals pdu_aou_req.
REQ-021 A DIV/CR/CLR/MR write in BUSY SHALL set pslverr=1 for that access, with no pulse, no req toggle and wdata unchanged.
REQ-022 EOI write SHALL pulse pdu_aou_int_clr[i] for every set pwdata[i], i<NUM_MATCH, in either FSM state, never erroring.
REQ-023 aou_pdu_cnt SHALL pass a two-flop synchroniser then a stability filter: cnt_sync updates only when two consecutive synchronised samples are equal, otherwise holds.
REQ-024 test_mode=1 SHALL route aou_pdu_cnt directly to CNT readback.
REQ-025 intr SHALL equal, one cycle later, OR over i of aou_pdu_int_flag[i] & ~aou_pdu_intr_mask[i].
REQ-026 Writes to unmapped, RO or MR[i>=NUM_MATCH] addresses SHALL be ignored, pslverr=0.

Reset
REQ-027 presetn low SHALL asynchronously set FSM=IDLE and clear pdu_aou_req, wdata, all wen/int_clr pulses, intr, pslverr, prdata, synchroniser flops and cnt_sync.
REQ-028 Reset in BUSY SHALL abandon the transfer; AOU side is reset from the same source.

Structure
REQ-029 Package rtc_pdu_pkg SHALL hold address offsets, the IDLE/BUSY state encoding and parameter range limits.
REQ-030 Sub-module rtc_cnt_sync_filter (parametrised width, sync plus stability filter, test_mode bypass) SHALL be instantiated once.

Verification
REQ-031 Write DIV=0x000A5 idle -> wen_div one pulse, wdata=0xA5, req 0->1, STAT=1 until ack toggles, then 0 two cycles later.
REQ-032 Write MR[1]=0x1234 while BUSY -> pslverr=1, no wen_mr, wdata unchanged.
REQ-033 aou_pdu_cnt flips 0x0000FFFF->0x00010000 glitching for one cycle -> CNT never reads a value other than the two stable values.
REQ-034 EOI write 0x3 while BUSY -> int_clr=2'b11 one cycle, pslverr=0.
REQ-035 flag=2'b10, mask=2'b00 -> intr=1 next cycle; mask=2'b10 -> intr=0; INT_RAW=0x2, INT_STAT=0x0.
REQ-036 presetn low mid-BUSY -> req=0, STAT=0, all pulses 0 immediately; next write accepted.
